// File: rtl/mesh_pkg.sv
// Shared mesh geometry and contour-stream FSM states.
// Used by the mesh, contour and point-streamer modules.
package mesh_pkg;

  localparam int COLS    = 26;
  localparam int ROWS    = 18;
  localparam int CELLS   = COLS * ROWS;
  localparam int IDX_W   = 9;
  localparam int COORD_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EMIT,
    DONE
  } state_t;

endpackage

// File: rtl/contour_any_pending.sv
// Reports whether any pending cell other than idx is still set.
// Ports: pending (CELLS map), idx (cell to ignore), any_other (OR result).
module contour_any_pending
  import mesh_pkg::*;
(
  input  logic [CELLS-1:0] pending,
  input  logic [IDX_W-1:0] idx,
  output logic             any_other
);

  logic [CELLS-1:0] mask;

  assign mask      = {{(CELLS-1){1'b0}}, 1'b1} << idx;
  assign any_other = |(pending & ~mask);

endmodule

// File: rtl/contour_point_streamer.sv
// Latches a contour map and streams (row, col) of every 0 cell in raster order.
// Ports: clk, rst, contour/frame_valid/frame_ready in, pt_* valid/ready out,
// pt_count (accepted points), frame_done (one-cycle completion pulse).
module contour_point_streamer
  import mesh_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [CELLS-1:0]   contour,
  input  logic               frame_valid,
  output logic               frame_ready,
  output logic               pt_valid,
  input  logic               pt_ready,
  output logic [COORD_W-1:0] pt_row,
  output logic [COORD_W-1:0] pt_col,
  output logic [IDX_W-1:0]   pt_index,
  output logic               pt_last,
  output logic [IDX_W-1:0]   pt_count,
  output logic               frame_done
);

  state_t             state;
  logic [CELLS-1:0]   pending;
  logic [IDX_W-1:0]   idx;
  logic [COORD_W-1:0] row;
  logic [COORD_W-1:0] col;

  logic               any_other;
  logic               at_end;
  logic [IDX_W-1:0]   nxt_idx;
  logic [COORD_W-1:0] nxt_row;
  logic [COORD_W-1:0] nxt_col;

  contour_any_pending u_any (
    .pending   (pending),
    .idx       (idx),
    .any_other (any_other)
  );

  assign at_end = (idx == IDX_W'(CELLS - 1));

  // Row and column are tracked as separate counters so no divider is needed.
  always_comb begin
    nxt_idx = idx + 1'b1;
    nxt_row = row;
    nxt_col = col + 1'b1;
    if (col == COORD_W'(COLS - 1)) begin
      nxt_col = '0;
      nxt_row = row + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pending     <= '0;
      idx         <= '0;
      row         <= '0;
      col         <= '0;
      frame_ready <= 1'b1;
      pt_valid    <= 1'b0;
      pt_row      <= '0;
      pt_col      <= '0;
      pt_index    <= '0;
      pt_last     <= 1'b0;
      pt_count    <= '0;
      frame_done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (frame_valid && frame_ready) begin
            pending     <= ~contour;
            idx         <= '0;
            row         <= '0;
            col         <= '0;
            pt_count    <= '0;
            frame_ready <= 1'b0;
            state       <= SCAN;
          end
        end
        SCAN: begin
          if (pending[idx]) begin
            pt_row   <= row;
            pt_col   <= col;
            pt_index <= idx;
            pt_last  <= ~any_other;
            pt_valid <= 1'b1;
            state    <= EMIT;
          end else if (at_end) begin
            frame_done <= 1'b1;
            state      <= DONE;
          end else begin
            idx <= nxt_idx;
            row <= nxt_row;
            col <= nxt_col;
          end
        end
        EMIT: begin
          if (pt_valid && pt_ready) begin
            pending[idx] <= 1'b0;
            pt_count     <= pt_count + 1'b1;
            pt_valid     <= 1'b0;
            if (pt_last || at_end) begin
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              idx   <= nxt_idx;
              row   <= nxt_row;
              col   <= nxt_col;
              state <= SCAN;
            end
          end
        end
        DONE: begin
          frame_done  <= 1'b0;
          frame_ready <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_contour_point_streamer.sv
// Scoreboard bench for contour_point_streamer.
// Directed maps; expected points queued, monitor compares on handshake.
module tb_contour_point_streamer;

  localparam int N = 468;

  typedef struct packed {
    logic [4:0] r;
    logic [4:0] c;
    logic [8:0] i;
    logic       l;
  } pt_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] contour = '1;
  logic         frame_valid = 1'b0;
  logic         frame_ready;
  logic         pt_valid;
  logic         pt_ready = 1'b1;
  logic [4:0]   pt_row;
  logic [4:0]   pt_col;
  logic [8:0]   pt_index;
  logic         pt_last;
  logic [8:0]   pt_count;
  logic         frame_done;

  int npass = 0;
  int ntot  = 0;
  pt_t q[$];

  always #5 clk = ~clk;

  contour_point_streamer dut (
    .clk         (clk),
    .rst         (rst),
    .contour     (contour),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .pt_valid    (pt_valid),
    .pt_ready    (pt_ready),
    .pt_row      (pt_row),
    .pt_col      (pt_col),
    .pt_index    (pt_index),
    .pt_last     (pt_last),
    .pt_count    (pt_count),
    .frame_done  (frame_done)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic pt_t mk(input int i, input logic l);
    pt_t p;
    p.r = 5'(i / 26);
    p.c = 5'(i % 26);
    p.i = 9'(i);
    p.l = l;
    return p;
  endfunction

  // Monitor: compare on handshake, check stability while stalled.
  pt_t cur;
  pt_t held;
  logic stalled = 1'b0;

  always @(negedge clk) begin
    cur = {pt_row, pt_col, pt_index, pt_last};
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid", 32'(pt_valid), 32'd1);
        check("stall_hold", 32'(cur), 32'(held));
      end
      if (pt_valid && pt_ready) begin
        if (q.size() == 0) begin
          check("unexpected_point", 32'(cur), 32'hFFFFF);
        end else begin
          check("point", 32'(cur), 32'(q.pop_front()));
        end
      end
      stalled = pt_valid && !pt_ready;
      held    = cur;
    end
  end

  task automatic accept(input logic [N-1:0] map);
    int w = 0;
    while (!frame_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    contour     = map;
    frame_valid = 1'b1;
    @(posedge clk); #1;
    frame_valid = 1'b0;
    contour     = ~map;
  endtask

  // Cycle n = state after the n-th rising edge following the accept edge.
  task automatic run(input int stall_n, output int tv, output int td,
                     output int tr, output int nd);
    tv = -1; td = -1; tr = -1; nd = 0;
    for (int n = 1; n <= 2000; n++) begin
      @(posedge clk); #1;
      if (stall_n > 0 && n == stall_n) pt_ready = 1'b0;
      if (stall_n > 0 && n == stall_n + 5) pt_ready = 1'b1;
      if (pt_valid && tv < 0) tv = n;
      if (frame_done) begin
        nd++;
        if (td < 0) td = n;
      end
      if (frame_ready) begin
        tr = n;
        break;
      end
    end
  endtask

  logic [N-1:0] m;
  int tv, td, tr, nd;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_frame_ready", 32'(frame_ready), 32'd1);
    check("rst_pt_valid", 32'(pt_valid), 32'd0);
    check("rst_pt_coord", 32'({pt_row, pt_col, pt_index, pt_last}), 32'd0);
    check("rst_pt_count", 32'(pt_count), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Only cell 0.
    m = '1; m[0] = 1'b0;
    q.push_back(mk(0, 1'b1));
    accept(m);
    run(0, tv, td, tr, nd);
    check("c0_valid_cyc", 32'(tv), 32'd1);
    check("c0_done_cyc", 32'(td), 32'd2);
    check("c0_done_pulses", 32'(nd), 32'd1);
    check("c0_count", 32'(pt_count), 32'd1);
    check("c0_q_empty", 32'(q.size()), 32'd0);

    // Only cell 467.
    m = '1; m[467] = 1'b0;
    q.push_back(mk(467, 1'b1));
    accept(m);
    run(0, tv, td, tr, nd);
    check("c467_valid_cyc", 32'(tv), 32'd468);
    check("c467_done_cyc", 32'(td), 32'd469);
    check("c467_count", 32'(pt_count), 32'd1);
    check("c467_q_empty", 32'(q.size()), 32'd0);

    // Cells 25 and 26: column wrap.
    m = '1; m[25] = 1'b0; m[26] = 1'b0;
    q.push_back({5'd0, 5'd25, 9'd25, 1'b0});
    q.push_back({5'd1, 5'd0, 9'd26, 1'b1});
    accept(m);
    run(0, tv, td, tr, nd);
    check("wrap_valid_cyc", 32'(tv), 32'd26);
    check("wrap_done_cyc", 32'(td), 32'd29);
    check("wrap_count", 32'(pt_count), 32'd2);
    check("wrap_q_empty", 32'(q.size()), 32'd0);

    // Empty frame.
    m = '1;
    accept(m);
    run(0, tv, td, tr, nd);
    check("empty_no_valid", 32'(tv), 32'hFFFFFFFF);
    check("empty_done_cyc", 32'(td), 32'd468);
    check("empty_ready_cyc", 32'(tr), 32'd469);
    check("empty_done_pulses", 32'(nd), 32'd1);
    check("empty_count", 32'(pt_count), 32'd0);

    // Full frame with a 5-cycle stall mid-stream.
    m = '0;
    for (int i = 0; i < N; i++) q.push_back(mk(i, i == N - 1));
    accept(m);
    run(50, tv, td, tr, nd);
    check("full_valid_cyc", 32'(tv), 32'd1);
    check("full_done_cyc", 32'(td), 32'd940);
    check("full_count", 32'(pt_count), 32'd468);
    check("full_q_empty", 32'(q.size()), 32'd0);

    // Reset while index 100 is on the output.
    m = '0;
    for (int i = 0; i < N; i++) q.push_back(mk(i, i == N - 1));
    accept(m);
    for (int n = 0; n < 400; n++) begin
      @(posedge clk); #1;
      if (pt_valid && pt_index == 9'd100) break;
    end
    check("pre_rst_index", 32'(pt_index), 32'd100);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(pt_valid), 32'd0);
    check("mid_rst_ready", 32'(frame_ready), 32'd1);
    check("mid_rst_coord", 32'({pt_row, pt_col, pt_index, pt_last}), 32'd0);
    check("mid_rst_count", 32'(pt_count), 32'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    m = '1; m[3] = 1'b0;
    q.push_back({5'd0, 5'd3, 9'd3, 1'b1});
    accept(m);
    run(0, tv, td, tr, nd);
    check("post_rst_valid_cyc", 32'(tv), 32'd4);
    check("post_rst_count", 32'(pt_count), 32'd1);
    check("post_rst_q_empty", 32'(q.size()), 32'd0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
